branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal branch predictor with BTB: 2-bit counters, tags and targets per entry.
// Define BP_STATS_EN to add the stat_branches / stat_mispredicts counters and ports.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_branch_taken,
  input  logic        ex_pred_taken,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned TagW = 30 - IdxW;

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [1:0]        cnt_q    [ENTRIES];
  logic [1:0]        cnt_d    [ENTRIES];
  logic [TagW-1:0]   tag_q    [ENTRIES];
  logic [TagW-1:0]   tag_d    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [31:0]       target_d [ENTRIES];

  logic [IdxW-1:0]   if_idx, ex_idx;
  logic [TagW-1:0]   if_tag, ex_tag;
  logic              if_hit, ex_hit, upd_en;
  logic              unused_pc_bits;

  assign if_idx = if_pc[IdxW+1:2];
  assign if_tag = if_pc[31:IdxW+2];
  assign ex_idx = ex_pc[IdxW+1:2];
  assign ex_tag = ex_pc[31:IdxW+2];
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd_en = ex_valid && ex_is_branch;

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    pred_taken  = if_hit && cnt_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);
    mispredict  = upd_en && (ex_branch_taken != ex_pred_taken);
    redirect_pc = ex_branch_taken ? ex_target : (ex_pc + 32'd4);
  end

  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_en) begin
      if (ex_branch_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        if (!ex_hit) begin
          cnt_d[ex_idx] = 2'b10;
        end else if (cnt_q[ex_idx] != 2'b11) begin
          cnt_d[ex_idx] = cnt_q[ex_idx] + 2'd1;
        end
      end else if (ex_hit && (cnt_q[ex_idx] != 2'b00)) begin
        // Not-taken misses never allocate.
        cnt_d[ex_idx] = cnt_q[ex_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= 2'b01;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = upd_en ? (stat_br_q + 32'd1) : stat_br_q;
    stat_mp_d = mispredict ? (stat_mp_q + 32'd1) : stat_mp_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor with a queue scoreboard of expected outputs.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        ex_valid, ex_is_branch;
  logic [31:0] ex_pc, ex_target;
  logic        ex_branch_taken, ex_pred_taken;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int tests  = 0;
  int failed = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_pc           (if_pc),
    .ex_valid        (ex_valid),
    .ex_is_branch    (ex_is_branch),
    .ex_pc           (ex_pc),
    .ex_target       (ex_target),
    .ex_branch_taken (ex_branch_taken),
    .ex_pred_taken   (ex_pred_taken),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ev;
    logic        eb;
    logic [31:0] epc;
    logic [31:0] etgt;
    logic        et;
    logic        ep;
    logic [31:0] ipc;
    logic        xpt;
    logic [31:0] xptgt;
    logic        xmp;
    logic [31:0] xrpc;
  } vec_t;

  typedef struct {
    int          id;
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
  } exp_t;

  localparam int NVec = 22;
  vec_t vecs[NVec];
  exp_t sb[$];

  function automatic vec_t mk(logic rst, logic ev, logic eb, logic [31:0] epc,
                              logic [31:0] etgt, logic et, logic ep, logic [31:0] ipc,
                              logic xpt, logic [31:0] xptgt, logic xmp, logic [31:0] xrpc);
    vec_t v;
    v.rst = rst; v.ev = ev; v.eb = eb; v.epc = epc; v.etgt = etgt; v.et = et; v.ep = ep;
    v.ipc = ipc; v.xpt = xpt; v.xptgt = xptgt; v.xmp = xmp; v.xrpc = xrpc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_ex(logic ev, logic eb, logic [31:0] epc, logic [31:0] etgt,
                          logic et, logic ep);
    ex_valid = ev; ex_is_branch = eb; ex_pc = epc; ex_target = etgt;
    ex_branch_taken = et; ex_pred_taken = ep;
  endtask

  task automatic idle();
    drive_ex(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic apply(int id, vec_t v);
    exp_t e, got;
    reset = v.rst;
    if_pc = v.ipc;
    drive_ex(v.ev, v.eb, v.epc, v.etgt, v.et, v.ep);
    e.id = id; e.pt = v.xpt; e.ptgt = v.xptgt; e.mp = v.xmp; e.rpc = v.xrpc;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard_empty v%0d: got 0 entries expected 1", id);
    end else begin
      got = sb.pop_front();
      chk($sformatf("pred_taken v%0d", got.id), {31'd0, pred_taken}, {31'd0, got.pt});
      chk($sformatf("pred_target v%0d", got.id), pred_target, got.ptgt);
      chk($sformatf("mispredict v%0d", got.id), {31'd0, mispredict}, {31'd0, got.mp});
      if (got.mp) chk($sformatf("redirect_pc v%0d", got.id), redirect_pc, got.rpc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst ev eb epc etgt et ep | ipc | pt ptgt mp rpc
    vecs[0]  = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 32'h100, 0, 32'h104, 0, 32'h0);
    vecs[1]  = mk(0, 1, 1, 32'h100, 32'h80, 1, 0, 32'h100, 0, 32'h104, 1, 32'h80);
    vecs[2]  = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 32'h100, 1, 32'h80,  0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 32'h140, 0, 32'h144, 0, 32'h0);
    vecs[4]  = mk(0, 1, 1, 32'h100, 32'h80, 1, 1, 32'h100, 1, 32'h80,  0, 32'h0);
    vecs[5]  = mk(0, 1, 1, 32'h100, 32'h80, 1, 1, 32'h100, 1, 32'h80,  0, 32'h0);
    vecs[6]  = mk(0, 1, 1, 32'h100, 32'h80, 1, 1, 32'h100, 1, 32'h80,  0, 32'h0);
    vecs[7]  = mk(0, 1, 1, 32'h100, 32'h80, 0, 1, 32'h100, 1, 32'h80,  1, 32'h104);
    vecs[8]  = mk(0, 1, 1, 32'h100, 32'h80, 0, 1, 32'h100, 1, 32'h80,  1, 32'h104);
    vecs[9]  = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 32'h100, 0, 32'h104, 0, 32'h0);
    vecs[10] = mk(0, 0, 1, 32'h200, 32'h40, 1, 0, 32'h200, 0, 32'h204, 0, 32'h0);
    vecs[11] = mk(0, 1, 0, 32'h200, 32'h40, 1, 0, 32'h200, 0, 32'h204, 0, 32'h0);
    vecs[12] = mk(0, 1, 1, 32'h300, 32'h40, 0, 1, 32'h200, 0, 32'h204, 1, 32'h304);
    vecs[13] = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 32'h300, 0, 32'h304, 0, 32'h0);
    vecs[14] = mk(0, 1, 1, 32'hFFFF_FFFC, 32'h40, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h0);
    vecs[15] = mk(1, 1, 1, 32'h600, 32'h40, 1, 0, 32'h600, 0, 32'h604, 1, 32'h40);
    vecs[16] = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 32'h600, 0, 32'h604, 0, 32'h0);
    vecs[17] = mk(0, 1, 1, 32'h600, 32'h40, 1, 0, 32'h600, 0, 32'h604, 1, 32'h40);
    vecs[18] = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 32'h600, 1, 32'h40,  0, 32'h0);
    vecs[19] = mk(1, 0, 0, 32'h0,   32'h0,  0, 0, 32'h600, 1, 32'h40,  0, 32'h0);
    vecs[20] = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 32'h600, 0, 32'h604, 0, 32'h0);
    vecs[21] = mk(0, 0, 0, 32'h0,   32'h0,  0, 0, 32'h100, 0, 32'h104, 0, 32'h0);

    reset = 1'b1;
    if_pc = 32'h100;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NVec; i++) apply(i, vecs[i]);
    reset = 1'b0;
    idle();

`ifdef BP_STATS_EN
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("stat_branches_after_reset", stat_branches, 32'd0);
    drive_ex(1'b1, 1'b1, 32'h700, 32'h40, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_ex(1'b1, 1'b1, 32'h704, 32'h40, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive_ex(1'b1, 1'b1, 32'h708, 32'h40, 1'b0, 1'b1);
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
    chk("stat_branches", stat_branches, 32'd3);
    chk("stat_mispredicts", stat_mispredicts, 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("stat_branches_reset", stat_branches, 32'd0);
    chk("stat_mispredicts_reset", stat_mispredicts, 32'd0);
`endif

    if (sb.size() != 0) begin
      tests++; failed++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
